slowmem_mc: RTL and testbench

//  Multi-channel, parametrised successor to the single-port slow memory.
//  NCH independent requesters (one per processor thread/PID) share one memory array.

---
 rtl/slowmem_mc_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/slowmem_mc.sv | 97 +++++++++
 tb/tb_slowmem_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/slowmem_mc_pkg.sv
// rtl/slowmem_mc_pkg.sv - shared widths, defaults and helpers for the multi-channel slow memory
package slowmem_mc_pkg;

  localparam int WORD_W   = 16;
  localparam int MADDR_W  = 16;
  localparam int MEMDELAY = 4;
  localparam int PID_W    = 1;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first requester at or after ptr wins, one-hot grant
module rr_arbiter
  import slowmem_mc_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = ptr_width(NCH)
) (
  input  logic [NCH-1:0] strobe,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  grant_idx
);

  always_comb begin
    logic found;
    int   c;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr) + i) % NCH;
      if (!found && strobe[c]) begin
        grant[c]  = 1'b1;
        grant_idx = PW'(c);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slowmem_mc.sv
// rtl/slowmem_mc.sv - multi-channel fixed-latency memory with round-robin request acceptance
module slowmem_mc
  import slowmem_mc_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ADDR_W = MADDR_W,
  parameter int DATA_W = WORD_W,
  parameter int DELAY  = MEMDELAY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        strobe,
  input  logic [NCH-1:0]        rnotw,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH-1:0]        accept,
  output logic [NCH-1:0]        mfc,
  output logic [NCH*DATA_W-1:0] rdata,
  output logic [NCH-1:0]        busy
);

  localparam int PW = ptr_width(NCH);
  localparam int CW = $clog2(DELAY + 1);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .strobe    (strobe),
    .ptr       (ptr),
    .grant     (accept),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (|accept)
      ptr <= (grant_idx == PW'(NCH-1)) ? '0 : grant_idx + PW'(1);
  end

  assign wr_en   = |(accept & ~rnotw);
  assign wr_addr = addr[grant_idx*ADDR_W +: ADDR_W];
  assign wr_data = wdata[grant_idx*DATA_W +: DATA_W];

  // Array contents survive reset; only the single shared write port touches it.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CW-1:0]     pend;
    logic [ADDR_W-1:0] raddr;
    logic              mfc_q;
    logic [DATA_W-1:0] rdata_q;

    // Write forwarding wins over a same-cycle normal completion; a new read
    // accept is applied last so it starts fresh even when a completion fires.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend    <= '0;
        raddr   <= '0;
        mfc_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        mfc_q   <= 1'b0;
        rdata_q <= '0;
        if (pend != '0 && wr_en && raddr == wr_addr) begin
          rdata_q <= wr_data;
          mfc_q   <= 1'b1;
          pend    <= '0;
        end else if (pend == CW'(1)) begin
          rdata_q <= mem[raddr];
          mfc_q   <= 1'b1;
          pend    <= '0;
        end else if (pend > CW'(1)) begin
          pend <= pend - CW'(1);
        end
        if (accept[c] && rnotw[c]) begin
          raddr <= addr[c*ADDR_W +: ADDR_W];
          pend  <= CW'(DELAY - 1);
        end
      end
    end

    assign mfc[c]                     = mfc_q;
    assign rdata[c*DATA_W +: DATA_W]  = rdata_q;
    assign busy[c]                    = (pend != '0);
  end

endmodule

// File: tb/tb_slowmem_mc.sv
// tb/tb_slowmem_mc.sv - directed self-checking bench for slowmem_mc (NCH=2, DELAY=4)
module tb_slowmem_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  strobe, rnotw, accept, mfc, busy;
  logic [31:0] addr, wdata, rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slowmem_mc #(.NCH(2), .ADDR_W(16), .DATA_W(16), .DELAY(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .rnotw  (rnotw),
    .addr   (addr),
    .wdata  (wdata),
    .accept (accept),
    .mfc    (mfc),
    .rdata  (rdata),
    .busy   (busy)
  );

  function automatic logic [15:0] rd(input int ch);
    return rdata[ch*16 +: 16];
  endfunction

  task automatic set_req(input int ch, input logic rnw, input logic [15:0] a, input logic [15:0] d);
    strobe[ch] = 1'b1;
    rnotw[ch]  = rnw;
    addr[ch*16 +: 16]  = a;
    wdata[ch*16 +: 16] = d;
  endtask

  task automatic drop(input int ch);
    strobe[ch] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int ch, input logic [15:0] a, input logic [15:0] d);
    set_req(ch, 1'b0, a, d);
    next_cycle();
    drop(ch);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobe = '0; rnotw = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mfc !== 2'b00) begin errors++; $display("FAIL reset_mfc got %h exp 0", mfc); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (accept !== 2'b00) begin errors++; $display("FAIL reset_accept got %h exp 0", accept); end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read();
    logic [15:0] exp_d;
    set_req(0, 1'b1, 16'h0010, 16'h0);
    @(negedge clk);
    checks++; if (accept !== 2'b01) begin errors++; $display("FAIL single_accept got %h exp 01", accept); end
    next_cycle();
    drop(0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_d = (k == 4) ? 16'hBEEF : 16'h0;
      checks++; if (mfc[0] !== (k == 4)) begin errors++; $display("FAIL single_mfc cyc %0d got %b exp %b", k, mfc[0], (k == 4)); end
      checks++; if (rd(0) !== exp_d) begin errors++; $display("FAIL single_rdata cyc %0d got %h exp %h", k, rd(0), exp_d); end
      checks++; if (busy[0] !== (k < 4)) begin errors++; $display("FAIL single_busy cyc %0d got %b exp %b", k, busy[0], (k < 4)); end
      next_cycle();
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_m;
    set_req(0, 1'b1, 16'h0010, 16'h0);
    set_req(1, 1'b1, 16'h0011, 16'h0);
    @(negedge clk);
    checks++; if (accept !== 2'b01) begin errors++; $display("FAIL arb_first got %h exp 01", accept); end
    next_cycle();
    drop(0);
    @(negedge clk);
    checks++; if (accept !== 2'b10) begin errors++; $display("FAIL arb_second got %h exp 10", accept); end
    next_cycle();
    drop(1);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      exp_m = {(k == 5), (k == 4)};
      checks++; if (mfc !== exp_m) begin errors++; $display("FAIL arb_mfc cyc %0d got %b exp %b", k, mfc, exp_m); end
      if (k == 4) begin
        checks++; if (rd(0) !== 16'hBEEF) begin errors++; $display("FAIL arb_rdata0 got %h exp beef", rd(0)); end
      end
      if (k == 5) begin
        checks++; if (rd(1) !== 16'hCAFE) begin errors++; $display("FAIL arb_rdata1 got %h exp cafe", rd(1)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_forward();
    set_req(0, 1'b1, 16'h0020, 16'h0);
    next_cycle();
    drop(0);
    next_cycle();
    set_req(1, 1'b0, 16'h0020, 16'h1234);
    @(negedge clk);
    checks++; if (accept !== 2'b10) begin errors++; $display("FAIL fwd_accept got %h exp 10", accept); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL fwd_busy_pre got %h exp 01", busy); end
    checks++; if (mfc !== 2'b00) begin errors++; $display("FAIL fwd_mfc_pre got %h exp 00", mfc); end
    next_cycle();
    drop(1);
    @(negedge clk);
    checks++; if (mfc !== 2'b01) begin errors++; $display("FAIL fwd_mfc got %b exp 01", mfc); end
    checks++; if (rd(0) !== 16'h1234) begin errors++; $display("FAIL fwd_rdata got %h exp 1234", rd(0)); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL fwd_busy_post got %h exp 00", busy); end
    next_cycle();
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      checks++; if (mfc !== 2'b00) begin errors++; $display("FAIL fwd_late_mfc cyc %0d got %b exp 00", k, mfc); end
      next_cycle();
    end
  endtask

  task automatic test_replace();
    set_req(0, 1'b1, 16'h0030, 16'h0);
    next_cycle();
    drop(0);
    next_cycle();
    set_req(0, 1'b1, 16'h0040, 16'h0);
    @(negedge clk);
    checks++; if (accept !== 2'b01) begin errors++; $display("FAIL repl_accept got %h exp 01", accept); end
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL repl_busy got %h exp 01", busy); end
    next_cycle();
    drop(0);
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (mfc[0] !== (k == 6)) begin errors++; $display("FAIL repl_mfc cyc %0d got %b exp %b", k, mfc[0], (k == 6)); end
      if (k == 6) begin
        checks++; if (rd(0) !== 16'h2222) begin errors++; $display("FAIL repl_rdata got %h exp 2222", rd(0)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read();
    set_req(1, 1'b0, 16'h8000, 16'h5A5A);
    next_cycle();
    set_req(1, 1'b1, 16'h8000, 16'h0);
    @(negedge clk);
    checks++; if (accept !== 2'b10) begin errors++; $display("FAIL wr_rd_accept got %h exp 10", accept); end
    next_cycle();
    drop(1);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (mfc[1] !== (k == 5)) begin errors++; $display("FAIL wr_rd_mfc cyc %0d got %b exp %b", k, mfc[1], (k == 5)); end
      if (k == 5) begin
        checks++; if (rd(1) !== 16'h5A5A) begin errors++; $display("FAIL wr_rd_rdata got %h exp 5a5a", rd(1)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midread();
    set_req(0, 1'b1, 16'h0010, 16'h0);
    next_cycle();
    drop(0);
    set_req(1, 1'b1, 16'h0011, 16'h0);
    next_cycle();
    drop(1);
    next_cycle();
    @(negedge clk);
    checks++; if (busy !== 2'b11) begin errors++; $display("FAIL rst_busy_both got %b exp 11", busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (mfc !== 2'b01) begin errors++; $display("FAIL rst_mfc_pre got %b exp 01", mfc); end
    checks++; if (busy !== 2'b10) begin errors++; $display("FAIL rst_busy_pre got %b exp 10", busy); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (mfc !== 2'b00) begin errors++; $display("FAIL rst_mfc_now got %b exp 00", mfc); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL rst_busy_now got %b exp 00", busy); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_now got %h exp 0", rdata); end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (mfc !== 2'b00) begin errors++; $display("FAIL rst_after_mfc cyc %0d got %b exp 00", k, mfc); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    preload(0, 16'h0010, 16'hBEEF);
    preload(1, 16'h0011, 16'hCAFE);
    preload(0, 16'h0030, 16'h1111);
    preload(1, 16'h0040, 16'h2222);
    test_single_read();
    preload(1, 16'h0050, 16'h0000);
    test_arbitration();
    test_forward();
    test_replace();
    test_write_then_read();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
